key_conditioner: RTL and testbench

Front-panel input conditioner between the board pins (KEY, SW) and the processor's execution-control inputs. Each push-button channel is synchronised, debounced and turned into a clean level plus one-cycle press/release pulses; the 8 slide switches are synchronised for the input port. At top level, `level[0]` drives processor `reset`, `level[1]` drives `stop`, and `sw_sync` feeds `INPORTin[7:0]`.

---
 rtl/key_conditioner_pkg.sv | 16 +
 rtl/key_debounce_ch.sv | 90 +++++++++
 rtl/key_conditioner.sv | 54 +++++
 tb/tb_key_conditioner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/key_conditioner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mini_src_pkg: shared debounce state encoding and default constants  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mini_src_pkg;

    localparam logic [1:0] C_ST_UP        = 2'd0;
    localparam logic [1:0] C_ST_WAIT_DOWN = 2'd1;
    localparam logic [1:0] C_ST_DOWN      = 2'd2;
    localparam logic [1:0] C_ST_WAIT_UP   = 2'd3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_debounce_ch: one button channel (sync, debounce FSM, pulses)    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module key_debounce_ch
    import mini_src_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int            CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= C_ST_UP;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= ~raw_n;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                C_ST_UP: begin
                    if (r_sync2) begin
                        r_state <= C_ST_WAIT_DOWN;
                        r_cnt   <= '0;
                    end
                end
                C_ST_WAIT_DOWN: begin
                    // Any released sample aborts the wait without a pulse
                    if (!r_sync2) begin
                        r_state <= C_ST_UP;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state <= C_ST_DOWN;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                C_ST_DOWN: begin
                    if (!r_sync2) begin
                        r_state <= C_ST_WAIT_UP;
                        r_cnt   <= '0;
                    end
                end
                C_ST_WAIT_UP: begin
                    if (r_sync2) begin
                        r_state <= C_ST_DOWN;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state   <= C_ST_UP;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= C_ST_UP;
            endcase
        end
    end

    assign level         = r_level;
    assign press         = r_press;
    assign release_pulse = r_release;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_conditioner: debounced push-buttons and synchronised switches   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module key_conditioner
    import mini_src_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_n,
    input  logic [7:0]       sw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic [7:0]       sw_sync
);

    logic [7:0] r_sw_meta;
    logic [7:0] r_sw_sync;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk          (CLOCK_50),
                .rst          (reset),
                .raw_n        (raw_n[i]),
                .level        (level[i]),
                .press        (press[i]),
                .release_pulse(release_pulse[i])
            );
        end
    endgenerate

    // Switches are levels read by software, so synchronisation alone suffices
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign sw_sync = r_sw_sync;

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_key_conditioner: randomized and directed bench vs run-length model|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_key_conditioner;

    localparam int W = 2;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] raw_n;
    logic [7:0]   sw_in;
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;
    logic [7:0]   sw_sync;

    always #5 clk = ~clk;

    key_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (rst),
        .raw_n        (raw_n),
        .sw_in        (sw_in),
        .level        (level),
        .press        (press),
        .release_pulse(rel),
        .sw_sync      (sw_sync)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a channel flips once the synchronised sample has disagreed
    // with the accepted level on N+1 consecutive edges.
    logic [W-1:0] m_k1 = '0, m_k2 = '0, m_level = '0, m_press = '0, m_rel = '0;
    logic [7:0]   m_sw1 = '0, m_sw2 = '0;
    int           m_run [W];

    task automatic model_edge();
        if (rst) begin
            m_k1 = '0; m_k2 = '0; m_level = '0; m_press = '0; m_rel = '0;
            m_sw1 = '0; m_sw2 = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < W; i++) begin
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                if (m_k2[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == N + 1) begin
                        m_level[i] = m_k2[i];
                        m_press[i] = m_k2[i];
                        m_rel[i]   = ~m_k2[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_k2  = m_k1;
            m_k1  = ~raw_n;
            m_sw2 = m_sw1;
            m_sw1 = sw_in;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("level", 32'(level), 32'(m_level));
        check("press", 32'(press), 32'(m_press));
        check("release", 32'(rel), 32'(m_rel));
        check("sw_sync", 32'(sw_sync), 32'(m_sw2));
        check("exclusive", 32'(press & rel), 32'd0);
    endtask

    // Runs n edges, recording the first edge (1-based) where the selected pulse is seen
    task automatic run_watch(input int n, input bit want_rel, output int first, output int count);
        first = 0;
        count = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if ((want_rel ? rel[0] : press[0]) === 1'b1) begin
                count++;
                if (first == 0) first = i;
            end
        end
    endtask

    int first, count;

    initial begin
        for (int i = 0; i < W; i++) m_run[i] = 0;
        rst   = 1'b1;
        raw_n = 2'b11;
        sw_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_sw_sync", 32'(sw_sync), 32'h00);
            check("rst_level", 32'(level), 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Clean press: rises on the 7th edge counted from the first low sample
        raw_n = 2'b10;
        run_watch(12, 1'b0, first, count);
        check("clean_press_edge", 32'(first), 32'd7);
        check("clean_press_count", 32'(count), 32'd1);
        check("clean_ch1_level", 32'(level[1]), 32'd0);

        raw_n = 2'b11;
        for (int i = 0; i < 10; i++) step();

        // Bounce before settling low
        raw_n = 2'b10;
        run_watch(3, 1'b0, first, count);
        check("bounce_early", 32'(count), 32'd0);
        raw_n = 2'b11;
        run_watch(1, 1'b0, first, count);
        check("bounce_early2", 32'(count), 32'd0);
        raw_n = 2'b10;
        run_watch(12, 1'b0, first, count);
        check("bounce_press_edge", 32'(first), 32'd7);
        check("bounce_press_count", 32'(count), 32'd1);

        // Release with a glitch
        raw_n = 2'b11;
        run_watch(2, 1'b1, first, count);
        raw_n = 2'b10;
        run_watch(1, 1'b1, first, count);
        check("glitch_level_held", 32'(level[0]), 32'd1);
        raw_n = 2'b11;
        run_watch(12, 1'b1, first, count);
        check("glitch_release_edge", 32'(first), 32'd7);
        check("glitch_release_count", 32'(count), 32'd1);

        // Reset while waiting on a held button
        for (int i = 0; i < 4; i++) step();
        raw_n = 2'b10;
        run_watch(4, 1'b0, first, count);
        rst = 1'b1;
        run_watch(3, 1'b0, first, count);
        check("reset_no_pulse", 32'(count), 32'd0);
        rst = 1'b0;
        run_watch(12, 1'b0, first, count);
        check("post_reset_press_edge", 32'(first), 32'd7);

        // Both channels together, plus a switch update
        raw_n = 2'b11;
        for (int i = 0; i < 10; i++) step();
        raw_n = 2'b00;
        sw_in = 8'h80;
        step();
        step();
        check("sw_two_edges", 32'(sw_sync), 32'h80);
        count = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (press == 2'b11) count++;
        end
        check("simultaneous_press", 32'(count), 32'd1);

        // Randomized soak
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(0, 6) == 0) raw_n[c] = ~raw_n[c];
            sw_in = 8'($urandom);
            rst   = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
